lcs_slot_responder: RTL and testbench
=====================================

Name: lcs_slot_responder

Overview:
- Parametrised responder on the LCS transmit side. On each request it raises ack and decides whether the current telemetry slot carries temperature bytes or normal LCS data.
- Sequences temperature-memory addresses across configurable byte groups, paces with a programmable delay, and guards against a stuck request with a timeout.
- Sits between the LCS transmit framer (req/ack/addr) and the temperature buffer RAM.

Parameters:
- ADDR_W, 9, width of LCS slot address
- DATA_W, 8, data byte width
- SLOT_BASE, 184, first LCS address routed to temperature data
- SLOT_COUNT, 4, number of consecutive temperature slots (1..2^ADDR_W-SLOT_BASE)
- BYTES_PER_GROUP, 4, temperature bytes per group before the group pointer advances (power of 2, ≥2)
- NGROUPS, 8, number of groups; group pointer wraps at NGROUPS-1
- TEMP_AW, 7, temperature RAM address width (must hold NGROUPS*BYTES_PER_GROUP-1)
- DELAY_TICKS, 10, ticks spent in DELAY (≥1)
- TIMEOUT_TICKS, 255, ticks allowed in WAIT before abort (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  transmit-edge enable; the FSM and counters advance only on clk edges with tick=1
- clr  in  1  synchronous clear of pointers and fault flag
- sw  in  1  temperature-insert enable, asynchronous source
- req  in  1  slot request, asynchronous source
- addr_lcs  in  ADDR_W  current LCS slot address, stable while req=1
- data_temp  in  DATA_W  byte from temperature RAM
- data_lcs  in  DATA_W  normal LCS byte
- ack  out  1  request acknowledge
- data_tx  out  DATA_W  temp_sel ? data_temp : data_lcs (combinational)
- addr_temp  out  TEMP_AW  group*BYTES_PER_GROUP + byte_idx (combinational, zero-extended)
- temp_sel  out  1  current byte taken from temperature RAM
- busy  out  1  state != IDLE
- timeout  out  1  sticky flag: a request stayed high too long

Behaviour:
- Reset (rst=0): ack=0, temp_sel=0, timeout=0, state=IDLE, byte_idx=0, group=0, delay and timeout counters=0. Synchroniser flops are cleared to 0.
- sw and req each pass through a 2-flop synchroniser clocked every clk edge, independent of tick. The FSM uses only the synchronised versions (sw_s, req_s).
- clr=1 on any clk edge, regardless of tick, has priority over everything:
  - byte_idx=0, group=0, timeout=0, ack=0, temp_sel=0, counters=0, state=IDLE.
- FSM, evaluated on tick edges only:
  - IDLE: if req_s=1 then ack<=1 and go to CHECK.
  - CHECK: hit = sw_s && SLOT_BASE ≤ addr_lcs ≤ SLOT_BASE+SLOT_COUNT-1.
    - On hit: temp_sel<=1. If byte_idx=BYTES_PER_GROUP-1, then byte_idx<=0 and group<=(group=NGROUPS-1 ? 0 : group+1); otherwise byte_idx<=byte_idx+1.
    - On no hit: temp_sel<=0 and pointers hold.
    - Either way, go to DELAY. Exactly one pointer step per request.
  - DELAY: count ticks; on the DELAY_TICKS-th tick in DELAY, clear the counter and go to WAIT.
  - WAIT:
    - If req_s=0: ack<=0 and go to IDLE. The wait counter is cleared.
    - Otherwise increment the wait counter. When it reaches TIMEOUT_TICKS: timeout<=1, ack<=0, go to ABORT.
  - ABORT: ack stays 0; go to IDLE when req_s=0. This prevents re-acking a stuck request.
- temp_sel holds its value from CHECK until the next CHECK, so data_tx is stable through DELAY/WAIT and the next IDLE.
- Latency: req rise → ack=1 on the first tick edge at least 2 clk edges after the rise. req fall → ack=0 on the first tick after synchronisation, only when in WAIT. A req fall during DELAY is acted on once WAIT is reached.
- addr_lcs changes while in WAIT/DELAY have no effect; it is sampled in CHECK only.
- Asynchronous reset mid-operation aborts immediately and returns all outputs to their reset values.

Test Plan:
- Reset then idle: hold rst=0, release, tick every clk, req=0 → ack=0, busy=0, addr_temp=0, data_tx=data_lcs.
- Temperature hit: sw=1, addr_lcs=185, pulse req for 20 ticks → ack rises ≤3 ticks after req, temp_sel=1, data_tx=data_temp, addr_temp goes 0→1, ack falls after req falls, with ≥10 ticks between ack rise and fall.
- Group wrap: sw=1, addr_lcs=184, 32 handshakes → addr_temp steps 1..31 and then back to 0, since group wraps 7→0.
- Miss paths: sw=0 with addr_lcs=186, and sw=1 with addr_lcs=188 and 183 → temp_sel=0, data_tx=data_lcs, addr_temp unchanged.
- Timeout: sw=1, addr_lcs=184, hold req=1 → timeout=1 and ack=0 after DELAY_TICKS+TIMEOUT_TICKS ticks, no re-ack while req stays high. Release req → IDLE. clr=1 → timeout=0, addr_temp=0.
- tick gating/reset: with tick=0 and req=1, ack stays 0. Assert rst in DELAY → ack=0, busy=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/lcs_slot_responder_if.sv
// Handshake and data bundle between the LCS transmit framer, the temperature
// buffer RAM and the slot responder.
interface lcs_slot_responder_if #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TEMP_AW = 7
);
  logic               tick;
  logic               clr;
  logic               sw;
  logic               req;
  logic [ADDR_W-1:0]  addr_lcs;
  logic [DATA_W-1:0]  data_temp;
  logic [DATA_W-1:0]  data_lcs;
  logic               ack;
  logic [DATA_W-1:0]  data_tx;
  logic [TEMP_AW-1:0] addr_temp;
  logic               temp_sel;
  logic               busy;
  logic               timeout;

  modport master (
    output tick, clr, sw, req, addr_lcs, data_temp, data_lcs,
    input  ack, data_tx, addr_temp, temp_sel, busy, timeout
  );

  modport slave (
    input  tick, clr, sw, req, addr_lcs, data_temp, data_lcs,
    output ack, data_tx, addr_temp, temp_sel, busy, timeout
  );
endinterface

// File: rtl/lcs_slot_responder.sv
// Acknowledges LCS slot requests, steers temperature bytes into the configured
// slot window and walks the temperature RAM address one byte per hit.
module lcs_slot_responder #(
  parameter int ADDR_W          = 9,
  parameter int DATA_W          = 8,
  parameter int SLOT_BASE       = 184,
  parameter int SLOT_COUNT      = 4,
  parameter int BYTES_PER_GROUP = 4,
  parameter int NGROUPS         = 8,
  parameter int TEMP_AW         = 7,
  parameter int DELAY_TICKS     = 10,
  parameter int TIMEOUT_TICKS   = 255
) (
  input logic            clk,
  input logic            rst,
  lcs_slot_responder_if.slave bus
);

  localparam int BI_W  = (BYTES_PER_GROUP > 1) ? $clog2(BYTES_PER_GROUP) : 1;
  localparam int G_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int DLY_W = $clog2(DELAY_TICKS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [ADDR_W:0]  SLOT_LO   = (ADDR_W+1)'(SLOT_BASE);
  localparam logic [ADDR_W:0]  SLOT_HI   = (ADDR_W+1)'(SLOT_BASE + SLOT_COUNT - 1);
  localparam logic [BI_W-1:0]  BYTE_LAST = BI_W'(BYTES_PER_GROUP - 1);
  localparam logic [G_W-1:0]   GRP_LAST  = G_W'(NGROUPS - 1);
  localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(DELAY_TICKS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DELAY,
    S_WAIT,
    S_ABORT
  } state_t;

  state_t            state_q;
  logic              req_meta_q, req_s_q;
  logic              sw_meta_q, sw_s_q;
  logic              ack_q, temp_sel_q, timeout_q;
  logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
  logic [G_W-1:0]    group_q, group_d;
  logic [DLY_W-1:0]  dly_cnt_q;
  logic [TO_W-1:0]   wait_cnt_q;
  logic              hit_d;
  logic [DATA_W-1:0] data_tx_d;

  // Two-flop synchronisers run every clk, independent of tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      sw_meta_q  <= 1'b0;
      sw_s_q     <= 1'b0;
    end else begin
      req_meta_q <= bus.req;
      req_s_q    <= req_meta_q;
      sw_meta_q  <= bus.sw;
      sw_s_q     <= sw_meta_q;
    end
  end

  always_comb begin
    hit_d      = sw_s_q && ({1'b0, bus.addr_lcs} >= SLOT_LO) && ({1'b0, bus.addr_lcs} <= SLOT_HI);
    byte_idx_d = byte_idx_q + BI_W'(1);
    group_d    = group_q;
    if (byte_idx_q == BYTE_LAST) begin
      byte_idx_d = '0;
      group_d    = (group_q == GRP_LAST) ? '0 : group_q + G_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      temp_sel_q <= 1'b0;
      timeout_q  <= 1'b0;
      byte_idx_q <= '0;
      group_q    <= '0;
      dly_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else if (bus.clr) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      temp_sel_q <= 1'b0;
      timeout_q  <= 1'b0;
      byte_idx_q <= '0;
      group_q    <= '0;
      dly_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else if (bus.tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (req_s_q) begin
            ack_q   <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Exactly one pointer step per acknowledged request.
          temp_sel_q <= hit_d;
          if (hit_d) begin
            byte_idx_q <= byte_idx_d;
            group_q    <= group_d;
          end
          state_q <= S_DELAY;
        end
        S_DELAY: begin
          if (dly_cnt_q == DLY_LAST) begin
            dly_cnt_q <= '0;
            state_q   <= S_WAIT;
          end else begin
            dly_cnt_q <= dly_cnt_q + DLY_W'(1);
          end
        end
        S_WAIT: begin
          if (!req_s_q) begin
            ack_q      <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= S_IDLE;
          end else if (wait_cnt_q == TO_LAST) begin
            timeout_q  <= 1'b1;
            ack_q      <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= S_ABORT;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
        end
        S_ABORT: begin
          // Hold off until the stuck request is released so it is never re-acked.
          if (!req_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_tx_d = temp_sel_q ? bus.data_temp : bus.data_lcs;
  end

  assign bus.data_tx   = data_tx_d;
  assign bus.addr_temp = TEMP_AW'(group_q) * TEMP_AW'(BYTES_PER_GROUP) + TEMP_AW'(byte_idx_q);
  assign bus.ack       = ack_q;
  assign bus.temp_sel  = temp_sel_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_lcs_slot_responder.sv
// Randomised handshake bench for lcs_slot_responder with a queue-based
// scoreboard fed from a linear temperature-pointer model.
module tb_lcs_slot_responder;
  localparam int ADDR_W        = 9;
  localparam int DATA_W        = 8;
  localparam int SLOT_BASE     = 184;
  localparam int SLOT_COUNT    = 4;
  localparam int BPG           = 4;
  localparam int NGROUPS       = 8;
  localparam int TEMP_AW       = 7;
  localparam int DELAY_TICKS   = 10;
  localparam int TIMEOUT_TICKS = 255;
  localparam int NPTR          = NGROUPS * BPG;

  typedef struct {
    bit temp_sel;
    int addr;
    int data;
    bit tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lcs_slot_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TEMP_AW(TEMP_AW)) bus();

  lcs_slot_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SLOT_BASE(SLOT_BASE), .SLOT_COUNT(SLOT_COUNT),
    .BYTES_PER_GROUP(BPG), .NGROUPS(NGROUPS), .TEMP_AW(TEMP_AW),
    .DELAY_TICKS(DELAY_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ptr   = 0;   // model: temperature byte pointer as one linear count mod NPTR
  bit   tmo_m = 1'b0;
  bit   tick_rand = 1'b0;
  bit   tick_en   = 1'b1;

  initial forever #5 clk = ~clk;

  initial begin
    bus.tick = tick_en;
    forever begin
      @(posedge clk); #1;
      bus.tick = tick_rand ? 1'($urandom_range(0, 1)) : tick_en;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack fall retires one expected transaction.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && prev && bus.ack === 1'b0) begin
        chk("sb_queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_temp_sel", bus.temp_sel, e.temp_sel);
          chk("sb_addr_temp", bus.addr_temp, e.addr);
          chk("sb_data_tx", bus.data_tx, e.data);
          chk("sb_timeout", bus.timeout, e.tmo);
        end
      end
      prev = rst ? (bus.ack === 1'b1) : 1'b0;
    end
  end

  // hold < 0 keeps req high until the responder aborts.
  task automatic handshake(input bit sw_v, input int a, input int hold, input bit timed);
    exp_t e;
    bit   hit;
    int   lat, n, re, dur_exp;
    @(posedge clk); #1;
    bus.sw        = sw_v;
    bus.addr_lcs  = ADDR_W'(a);
    bus.data_temp = DATA_W'($urandom);
    bus.data_lcs  = DATA_W'($urandom);
    hit = sw_v && (a >= SLOT_BASE) && (a < SLOT_BASE + SLOT_COUNT);
    if (hit) ptr = (ptr + 1) % NPTR;
    e.temp_sel = hit;
    e.addr     = ptr;
    e.data     = hit ? int'(bus.data_temp) : int'(bus.data_lcs);
    e.tmo      = tmo_m || (hold < 0);
    exp_q.push_back(e);
    bus.req = 1'b1;
    lat = 0;
    while (bus.ack !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.ack !== 1'b1) begin
      chk("ack_rise_bound", bus.ack, 1);
      bus.req = 1'b0;
      return;
    end
    if (timed) chk("ack_latency", lat, 3);
    if (hold >= 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      bus.req = 1'b0;
    end
    n = 0;
    while (bus.ack === 1'b1 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.ack === 1'b1) begin
      chk("ack_fall_bound", bus.ack, 0);
      bus.req = 1'b0;
      return;
    end
    if (hold < 0) begin
      if (timed) chk("timeout_dur", n, 1 + DELAY_TICKS + TIMEOUT_TICKS);
      re = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (bus.ack !== 1'b0) re++;
      end
      chk("no_reack", re, 0);
      bus.req = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      chk("abort_to_idle_busy", bus.busy, 0);
      tmo_m = 1'b1;
    end else begin
      dur_exp = (hold + 3 > DELAY_TICKS + 2) ? hold + 3 : DELAY_TICKS + 2;
      if (timed) chk("ack_high_dur", hold + n, dur_exp);
      chk("busy_after_handshake", bus.busy, 0);
    end
    @(negedge clk);
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    ptr   = 0;
    tmo_m = 1'b0;
    @(negedge clk);
    chk("clr_timeout", bus.timeout, 0);
    chk("clr_addr_temp", bus.addr_temp, 0);
    chk("clr_temp_sel", bus.temp_sel, 0);
  endtask

  initial begin
    int nack, lat;
    bus.clr       = 1'b0;
    bus.sw        = 1'b0;
    bus.req       = 1'b0;
    bus.addr_lcs  = '0;
    bus.data_temp = 8'h5A;
    bus.data_lcs  = 8'hA5;

    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_temp_sel", bus.temp_sel, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_addr_temp", bus.addr_temp, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_ack", bus.ack, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_addr_temp", bus.addr_temp, 0);
    chk("idle_data_tx", bus.data_tx, 8'hA5);

    handshake(1'b1, 185, 20, 1'b1);
    do_clr();

    for (int i = 0; i < NPTR; i++) handshake(1'b1, 184, $urandom_range(1, 8), 1'b1);

    handshake(1'b0, 186, 5, 1'b1);
    handshake(1'b1, 188, 5, 1'b1);
    handshake(1'b1, 183, 5, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int a;
      bit s;
      tick_rand = (i >= 20);
      s = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 4) != 0) ? int'($urandom_range(SLOT_BASE - 3, SLOT_BASE + SLOT_COUNT + 2))
                                      : int'($urandom_range(0, 511));
      handshake(s, a, $urandom_range(1, 25), !tick_rand);
    end
    tick_rand = 1'b0;

    tick_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.sw       = 1'b1;
    bus.addr_lcs = ADDR_W'(184);
    bus.req      = 1'b1;
    nack = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.ack !== 1'b0) nack++;
    end
    chk("tick_gate_ack", nack, 0);
    tick_en = 1'b1;
    lat = 0;
    while (bus.ack !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("tick_resume_ack", bus.ack, 1);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_ack", bus.ack, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_temp_sel", bus.temp_sel, 0);
    bus.req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b1;
    ptr   = 0;
    tmo_m = 1'b0;

    handshake(1'b1, 184, 3, 1'b1);

    handshake(1'b1, 184, -1, 1'b1);
    do_clr();

    repeat (5) @(negedge clk);
    chk("sb_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
